// File: rtl/fifo_frame_arbiter_pkg.sv
// Shared types and sizing for the two-source frame arbiter in front of the 2048x8 FIFO.
package fifo_arb_pkg;

    localparam int DEPTH     = 2048;
    localparam int DEPTH_W   = 11;
    localparam int DATA_W    = 8;
    localparam int MAX_FRAME = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    function automatic logic [1:0] idx_to_grant(input logic idx);
        idx_to_grant = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fifo_frame_arbiter_if.sv
// Source streams, FIFO write/observe signals and status of the frame arbiter.
interface fifo_frame_arbiter_if #(
    parameter int DATA_W  = fifo_arb_pkg::DATA_W,
    parameter int DEPTH_W = fifo_arb_pkg::DEPTH_W
);
    logic              src0_valid;
    logic [DATA_W-1:0] src0_data;
    logic              src0_last;
    logic              src0_ready;
    logic              src1_valid;
    logic [DATA_W-1:0] src1_data;
    logic              src1_last;
    logic              src1_ready;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_wr_full;
    logic              fifo_rd_en;
    logic              fifo_rd_empty;
    logic [1:0]        grant;
    logic [DEPTH_W:0]  level;
    logic              ovf_err;

    modport slave (
        input  src0_valid, src0_data, src0_last,
        output src0_ready,
        input  src1_valid, src1_data, src1_last,
        output src1_ready,
        output fifo_wr_en, fifo_wr_data,
        input  fifo_wr_full, fifo_rd_en, fifo_rd_empty,
        output grant, level, ovf_err
    );

    modport master (
        output src0_valid, src0_data, src0_last,
        input  src0_ready,
        output src1_valid, src1_data, src1_last,
        input  src1_ready,
        input  fifo_wr_en, fifo_wr_data,
        output fifo_wr_full, fifo_rd_en, fifo_rd_empty,
        input  grant, level, ovf_err
    );

endinterface

// File: rtl/fifo_frame_arbiter_level_tracker.sv
// Shadow occupancy counter of the FIFO, built from the write strobe and the effective read strobe.
module fifo_level_tracker
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH   = fifo_arb_pkg::DEPTH,
    parameter int DEPTH_W = fifo_arb_pkg::DEPTH_W,
    parameter int THRESH  = fifo_arb_pkg::MAX_FRAME
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             rd_empty,
    output logic [DEPTH_W:0] level,
    output logic             room
);
    localparam int LW = DEPTH_W + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(THRESH);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    logic          rd_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] space_s;

    // A read of an empty FIFO moves nothing, so it must not count
    assign rd_s    = rd_en & ~rd_empty;
    assign space_s = DEPTH_L - level_r;
    assign room    = (space_s >= THRESH_L);
    assign level   = level_r;

    // Occupancy counter; a same-cycle write and read cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {LW{1'b0}};
        end else begin
            case ({wr_en, rd_s})
                2'b10:   level_r <= level_r + ONE_L;
                2'b01:   level_r <= level_r - ONE_L;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_frame_arbiter.sv
// Round-robin frame arbiter: grants one source per frame, only when a worst-case frame fits.
module fifo_frame_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH     = fifo_arb_pkg::DEPTH,
    parameter int DEPTH_W   = fifo_arb_pkg::DEPTH_W,
    parameter int DATA_W    = fifo_arb_pkg::DATA_W,
    parameter int MAX_FRAME = fifo_arb_pkg::MAX_FRAME
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_frame_arbiter_if.slave  bus
);
    localparam int LW = DEPTH_W + 1;
    localparam logic [LW-1:0] BEAT_LAST = LW'(MAX_FRAME - 1);
    localparam logic [LW-1:0] BEAT_ONE  = LW'(1);

    arb_state_e        state_r;
    logic [1:0]        grant_r;
    logic              rr_r;
    logic [LW-1:0]     beat_r;
    logic              ovf_err_r;

    logic              room_s;
    logic              pick_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic              sel_ready_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              src0_ready_s;
    logic              src1_ready_s;
    logic [LW-1:0]     level_s;

    fifo_level_tracker #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W),
        .THRESH  (MAX_FRAME)
    ) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .rd_en    (bus.fifo_rd_en),
        .rd_empty (bus.fifo_rd_empty),
        .level    (level_s),
        .room     (room_s)
    );

    // Round-robin pick: on contention the source that did not win last time goes next
    always_comb begin
        pick_s = 1'b0;
        if (bus.src0_valid && bus.src1_valid) begin
            pick_s = ~rr_r;
        end else begin
            pick_s = bus.src1_valid;
        end
    end

    // Data mux and handshake for the granted source; the write path is combinational
    always_comb begin
        sel_ready_s  = 1'b0;
        sel_valid_s  = 1'b0;
        sel_last_s   = 1'b0;
        sel_data_s   = {DATA_W{1'b0}};
        case (state_r)
            XFER:    sel_ready_s = ~bus.fifo_wr_full;
            DROP:    sel_ready_s = 1'b1;
            default: sel_ready_s = 1'b0;
        endcase
        if (grant_r[1]) begin
            sel_valid_s = bus.src1_valid;
            sel_last_s  = bus.src1_last;
            sel_data_s  = bus.src1_data;
        end else begin
            sel_valid_s = bus.src0_valid;
            sel_last_s  = bus.src0_last;
            sel_data_s  = bus.src0_data;
        end
        accept_s     = sel_valid_s & sel_ready_s;
        src0_ready_s = grant_r[0] & sel_ready_s;
        src1_ready_s = grant_r[1] & sel_ready_s;
        if (state_r == XFER) begin
            wr_en_s = accept_s;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Frame FSM; grant, round-robin pointer, beat count and overflow pulse are all registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            grant_r   <= 2'b00;
            rr_r      <= 1'b1;
            beat_r    <= {LW{1'b0}};
            ovf_err_r <= 1'b0;
        end else begin
            ovf_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (room_s && (bus.src0_valid || bus.src1_valid)) begin
                        grant_r <= idx_to_grant(pick_s);
                        rr_r    <= pick_s;
                        beat_r  <= {LW{1'b0}};
                        state_r <= XFER;
                    end else begin
                        grant_r <= 2'b00;
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    if (accept_s) begin
                        beat_r <= beat_r + BEAT_ONE;
                        if (sel_last_s) begin
                            grant_r <= 2'b00;
                            state_r <= IDLE;
                        end else if (beat_r == BEAT_LAST) begin
                            // Byte MAX_FRAME is still written; the rest of the frame is discarded
                            ovf_err_r <= 1'b1;
                            state_r   <= DROP;
                        end else begin
                            state_r <= XFER;
                        end
                    end else begin
                        state_r <= XFER;
                    end
                end
                DROP: begin
                    if (accept_s && sel_last_s) begin
                        grant_r <= 2'b00;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    grant_r <= 2'b00;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.src0_ready   = src0_ready_s;
    assign bus.src1_ready   = src1_ready_s;
    assign bus.fifo_wr_en   = wr_en_s;
    assign bus.fifo_wr_data = sel_data_s;
    assign bus.grant        = grant_r;
    assign bus.level        = level_s;
    assign bus.ovf_err      = ovf_err_r;

endmodule

// File: doc/fifo_frame_arbiter.md
Name: fifo_frame_arbiter

Overview:
- Round-robin frame arbiter that lets two byte-stream sources share one 2048x8 synchronous FIFO write port.
- A grant is held for a whole frame, delimited by `last`. A new frame is granted only when the FIFO has room for a worst-case frame.
- The block tracks FIFO occupancy itself by observing write and read strobes. Frames longer than MAX_FRAME are truncated and the remaining bytes drained.
- Sits between the packet sources and the FIFO write side; the FIFO read side is driven by the downstream consumer.

Parameters:
- DEPTH, 2048, FIFO depth in bytes.
- DEPTH_W, 11, log2(DEPTH).
- DATA_W, 8, byte width.
- MAX_FRAME, 256, maximum frame length in bytes; also the free-space threshold for a grant. Legal range 1..DEPTH.

Ports:
- clk  in  1  single clock for the block and the FIFO.
- rst_n  in  1  asynchronous, active-low reset.
- src0_valid  in  1  source 0 byte valid.
- src0_data  in  DATA_W  source 0 byte.
- src0_last  in  1  source 0 last byte of frame.
- src0_ready  out  1  source 0 byte accepted when valid & ready.
- src1_valid / src1_data / src1_last / src1_ready  same as source 0, for source 1.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_W  FIFO write data.
- fifo_wr_full  in  1  FIFO full flag.
- fifo_rd_en  in  1  consumer read enable (observed only).
- fifo_rd_empty  in  1  FIFO empty flag (observed only).
- grant  out  2  one-hot current owner; 00 when idle.
- level  out  DEPTH_W+1  tracked FIFO occupancy, 0..DEPTH.
- ovf_err  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset values:
  - grant=00, level=0, ovf_err=0, src*_ready=0, fifo_wr_en=0.
  - State IDLE; round-robin pointer rr=1, so source 0 wins first.
  - Beat counter = 0.
- Reset is asynchronous on assertion. Reset mid-frame abandons the frame with no cleanup; the system resets the FIFO on the same rst_n.
- Occupancy:
  - rd = fifo_rd_en & ~fifo_rd_empty.
  - level <= level + fifo_wr_en − rd.
  - Simultaneous write and read leaves level unchanged.
  - space = DEPTH − level, computed at DEPTH_W+1 bits unsigned.
- States:
  - IDLE:
    - A source requests when its src_valid=1.
    - Eligible when space ≥ MAX_FRAME.
    - Both requesting: grant the source ≠ rr. One requesting: grant it.
    - On grant: set grant, rr <= granted index, beat counter <= 0, go to XFER. Readies stay 0 in this cycle, so grant-to-first-accept latency is 1 cycle.
    - Not eligible: stay in IDLE, no grant.
  - XFER:
    - Granted src_ready = ~fifo_wr_full; the other source's ready = 0.
    - fifo_wr_en = granted src_valid & src_ready, combinational (0-cycle write latency).
    - fifo_wr_data = granted src_data.
    - Each accepted byte increments the beat counter.
    - Accept with last=1: go to IDLE, grant <= 00.
    - Accept of byte number MAX_FRAME (counter == MAX_FRAME−1) with last=0: byte is written, ovf_err pulses next cycle, go to DROP.
    - Accept with last=1 on byte MAX_FRAME is a legal frame; no error.
  - DROP:
    - Granted src_ready = 1; fifo_wr_en = 0; bytes are discarded.
    - Accept with last=1: go to IDLE, grant <= 00.
- fifo_wr_full in XFER only stalls the source. It cannot occur when level accounting is correct; it is a safety interlock only.
- No back-to-back grant: every frame passes through one IDLE cycle, giving 1 bubble per frame.
- level never exceeds DEPTH by construction. Verification asserts level ≤ DEPTH and level == the FIFO's true count.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, XFER, DROP}.
  - Constants DEPTH, DEPTH_W, MAX_FRAME.
- One natural sub-module: fifo_level_tracker, holding the occupancy counter and the space ≥ threshold compare.
- The FSM and the 2:1 data mux stay in the top module.

Test Plan:
- Single source, 4-byte frame (0xA1..0xA4, last on 0xA4), fifo_rd_en=0:
  - grant=01 one cycle after src0_valid.
  - Four fifo_wr_en cycles carrying 0xA1..0xA4.
  - level=4; grant=00 the cycle after last.
- Both sources valid continuously with 2-byte frames:
  - Grants alternate 01,10,01,10.
  - No interleaving of bytes within a frame; one idle cycle between frames.
- Space gate, MAX_FRAME=256:
  - Fill level to 1793; src1_valid=1 → no grant (space 255).
  - One read (rd_en=1, empty=0) → level=1792 → grant=10 next cycle.
- Overrun, MAX_FRAME=256:
  - src0 sends a 300-byte frame.
  - Exactly 256 writes; ovf_err high for 1 cycle.
  - Remaining 44 bytes accepted with fifo_wr_en=0; back to IDLE after last.
- Simultaneous write and read at level=10 for 5 cycles → level stays 10. Read while empty is ignored (level stays 0).
- rst_n low mid-XFER (byte 3 of 8):
  - Same-cycle asynchronous clear: grant=00, ready=0, level=0, fifo_wr_en=0.
  - After release, a new frame is granted to src0 first.
